// File: rtl/result_writeback_pkg.sv
// ============================================================================
// Module      : result_writeback_pkg
// Description : Shared packet layout and field constants for result write-back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package result_writeback_pkg;

  localparam int PKT_W  = 143;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int UNIT_W = 3;
  localparam int LAT_W  = 3;

  // Field positions in the MSB-first [0:142] view of the packet
  localparam int WE_BIT  = 131;
  localparam int RT_LO   = 132;
  localparam int RT_HI   = 138;
  localparam int DATA_LO = 3;
  localparam int DATA_HI = 130;

  typedef struct packed {
    logic [UNIT_W-1:0] unit;
    logic [DATA_W-1:0] data;
    logic              we;
    logic [ADDR_W-1:0] rt;
    logic [LAT_W:0]    lat;
  } wb_pkt_t;

  function automatic wb_pkt_t make_pkt(
    input logic [UNIT_W-1:0] unit,
    input logic [DATA_W-1:0] data,
    input logic              we,
    input logic [ADDR_W-1:0] rt,
    input logic [LAT_W-1:0]  lat
  );
    make_pkt = '{unit: unit, data: data, we: we, rt: rt, lat: {1'b0, lat}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/result_writeback_delay_line.sv
// ============================================================================
// Module      : wb_delay_line
// Description : Per-pipe result delay line with insert, flush and hazard flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_delay_line
  import result_writeback_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          res_valid,
  input  wb_pkt_t                       res_pkt,
  input  logic [LAT_W-1:0]              res_lat,
  output wb_pkt_t                       head,
  output logic [DEPTH-1:0]              slot_vis,
  output logic [DEPTH-1:0][ADDR_W-1:0]  slot_rt,
  output logic [DEPTH-1:0][DATA_W-1:0]  slot_data,
  output logic                          hazard
);

  wb_pkt_t [DEPTH-1:0] r_line;
  wb_pkt_t [DEPTH-1:0] w_next;
  logic                r_hazard;
  logic                w_lat_ok;
  logic                w_insert;
  logic                w_collide;
  logic                w_hz_event;

  always_comb begin
    w_lat_ok  = (res_lat != '0) && (int'(res_lat) <= DEPTH);
    w_insert  = res_valid && w_lat_ok && !flush;
    w_collide = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      w_next[k] = r_line[k+1];
    end
    w_next[DEPTH-1] = '0;
    // Whatever would shift into the target slot is the packet being displaced
    for (int k = 0; k < DEPTH; k++) begin
      if (w_insert && (int'(res_lat) == k + 1)) begin
        w_collide = |w_next[k];
        w_next[k] = res_pkt;
      end
    end
    if (flush) begin
      w_next = '0;
    end
    w_hz_event = res_valid && !flush && (!w_lat_ok || w_collide);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_line   <= '0;
      r_hazard <= 1'b0;
    end else begin
      r_line <= w_next;
      if (w_hz_event) begin
        r_hazard <= 1'b1;
      end
    end
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      assign slot_vis[k]  = r_line[k].we;
      assign slot_rt[k]   = r_line[k].rt;
      assign slot_data[k] = r_line[k].data;
    end
  endgenerate

  assign head   = r_line[0];
  assign hazard = r_hazard;

endmodule

`default_nettype wire

// File: rtl/result_writeback.sv
// ============================================================================
// Module      : result_writeback
// Description : Dual-pipe result staging, write-back arbitration, forwarding.
//               Forwarding logic is built only when WB_FORWARD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int DEPTH     = 7,
  parameter int FWD_PORTS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ep_res_valid,
  input  logic [0:DATA_W-1]   ep_res_data,
  input  logic [ADDR_W-1:0]   ep_res_rt,
  input  logic                ep_res_we,
  input  logic [UNIT_W-1:0]   ep_res_unit,
  input  logic [LAT_W-1:0]    ep_res_lat,
  input  logic                op_res_valid,
  input  logic [0:DATA_W-1]   op_res_data,
  input  logic [ADDR_W-1:0]   op_res_rt,
  input  logic                op_res_we,
  input  logic [UNIT_W-1:0]   op_res_unit,
  input  logic [LAT_W-1:0]    op_res_lat,
  input  logic                flush,
  output logic [0:PKT_W-1]    wrt_back_arr_ep,
  output logic [0:PKT_W-1]    wrt_back_arr_op,
  output logic                wb_hazard,
  input  logic [ADDR_W-1:0]   fwd_addr  [FWD_PORTS],
  output logic                fwd_hit   [FWD_PORTS],
  output logic [0:DATA_W-1]   fwd_value [FWD_PORTS]
);

  wb_pkt_t                      w_ep_head, w_op_head, w_ep_out;
  logic                         w_ep_hazard, w_op_hazard;
  logic [DEPTH-1:0]             w_ep_vis, w_op_vis;
  logic [DEPTH-1:0][ADDR_W-1:0] w_ep_rt, w_op_rt;
  logic [DEPTH-1:0][DATA_W-1:0] w_ep_data, w_op_data;

  wb_delay_line #(.DEPTH(DEPTH)) u_ep_line (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .res_valid (ep_res_valid),
    .res_pkt   (make_pkt(ep_res_unit, ep_res_data, ep_res_we, ep_res_rt, ep_res_lat)),
    .res_lat   (ep_res_lat),
    .head      (w_ep_head),
    .slot_vis  (w_ep_vis),
    .slot_rt   (w_ep_rt),
    .slot_data (w_ep_data),
    .hazard    (w_ep_hazard)
  );

  wb_delay_line #(.DEPTH(DEPTH)) u_op_line (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .res_valid (op_res_valid),
    .res_pkt   (make_pkt(op_res_unit, op_res_data, op_res_we, op_res_rt, op_res_lat)),
    .res_lat   (op_res_lat),
    .head      (w_op_head),
    .slot_vis  (w_op_vis),
    .slot_rt   (w_op_rt),
    .slot_data (w_op_data),
    .hazard    (w_op_hazard)
  );

  // Odd pipe is younger in program order, so it keeps the register write
  always_comb begin
    w_ep_out = w_ep_head;
    if (w_ep_head.we && w_op_head.we && (w_ep_head.rt == w_op_head.rt)) begin
      w_ep_out.we = 1'b0;
    end
  end

  assign wrt_back_arr_ep = w_ep_out;
  assign wrt_back_arr_op = w_op_head;
  assign wb_hazard       = w_ep_hazard | w_op_hazard;

`ifdef WB_FORWARD_EN
  // Ascending scan: later hits override, giving highest slot then op priority
  always_comb begin
    for (int p = 0; p < FWD_PORTS; p++) begin
      fwd_hit[p]   = 1'b0;
      fwd_value[p] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (w_ep_vis[k] && (w_ep_rt[k] == fwd_addr[p])) begin
          fwd_hit[p]   = 1'b1;
          fwd_value[p] = w_ep_data[k];
        end
        if (w_op_vis[k] && (w_op_rt[k] == fwd_addr[p])) begin
          fwd_hit[p]   = 1'b1;
          fwd_value[p] = w_op_data[k];
        end
      end
    end
  end
`else
  logic w_unused_fwd;
  logic w_unused_slots;

  always_comb begin
    w_unused_fwd = 1'b0;
    for (int p = 0; p < FWD_PORTS; p++) begin
      fwd_hit[p]   = 1'b0;
      fwd_value[p] = '0;
      w_unused_fwd = w_unused_fwd ^ (^fwd_addr[p]);
    end
  end

  assign w_unused_slots = ^{w_ep_vis, w_ep_rt, w_ep_data, w_op_vis, w_op_rt, w_op_data};
`endif

endmodule

`default_nettype wire

// File: tb/tb_result_writeback.sv
// ============================================================================
// Module      : tb_result_writeback
// Description : Scoreboard bench for result_writeback with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_writeback;

  localparam int DEPTH = 7;
  localparam int FWDP  = 5;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           ep_res_valid = 1'b0, op_res_valid = 1'b0;
  logic [0:127]   ep_res_data = '0, op_res_data = '0;
  logic [6:0]     ep_res_rt = '0, op_res_rt = '0;
  logic           ep_res_we = 1'b0, op_res_we = 1'b0;
  logic [2:0]     ep_res_unit = '0, op_res_unit = '0;
  logic [2:0]     ep_res_lat = '0, op_res_lat = '0;
  logic           flush = 1'b0;
  logic [0:142]   wrt_back_arr_ep, wrt_back_arr_op;
  logic           wb_hazard;
  logic [6:0]     fwd_addr  [FWDP];
  logic           fwd_hit   [FWDP];
  logic [0:127]   fwd_value [FWDP];

  result_writeback #(.DEPTH(DEPTH), .FWD_PORTS(FWDP)) dut (
    .clock           (clock),
    .reset           (reset),
    .ep_res_valid    (ep_res_valid),
    .ep_res_data     (ep_res_data),
    .ep_res_rt       (ep_res_rt),
    .ep_res_we       (ep_res_we),
    .ep_res_unit     (ep_res_unit),
    .ep_res_lat      (ep_res_lat),
    .op_res_valid    (op_res_valid),
    .op_res_data     (op_res_data),
    .op_res_rt       (op_res_rt),
    .op_res_we       (op_res_we),
    .op_res_unit     (op_res_unit),
    .op_res_lat      (op_res_lat),
    .flush           (flush),
    .wrt_back_arr_ep (wrt_back_arr_ep),
    .wrt_back_arr_op (wrt_back_arr_op),
    .wb_hazard       (wb_hazard),
    .fwd_addr        (fwd_addr),
    .fwd_hit         (fwd_hit),
    .fwd_value       (fwd_value)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // In-flight result as the model sees it: pipe 0 = even, 1 = odd
  typedef struct {
    int         due;
    int         pipe;
    logic [2:0] unit;
    logic [127:0] data;
    logic       we;
    logic [6:0] rt;
    logic [2:0] lat;
  } fl_t;

  typedef struct {
    int                     cyc;
    logic [142:0]           ep;
    logic [142:0]           op;
    logic                   hz;
    logic [FWDP-1:0]        hit;
    logic [FWDP-1:0][127:0] val;
  } exp_t;

  fl_t  inflight[$];
  exp_t sbq[$];
  bit   m_hz = 1'b0;

  // Staged stimulus for the next tick
  logic         s_rst = 1'b1;
  logic         s_flush = 1'b0;
  logic         s_v    [2] = '{1'b0, 1'b0};
  logic [127:0] s_data [2];
  logic [6:0]   s_rt   [2];
  logic         s_we   [2];
  logic [2:0]   s_unit [2];
  logic [2:0]   s_lat  [2];
  logic [6:0]   nxt_fwd [FWDP];
  logic [6:0]   d_fwd   [FWDP];
  bit           d_fwd_set = 1'b0;

  int tests = 0;
  int fails = 0;

  function automatic logic [142:0] pkt_of(fl_t e);
    return {e.unit, e.data, e.we, e.rt, 1'b0, e.lat};
  endfunction

  task automatic check(string name, logic [142:0] act, logic [142:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic stage(int p, logic [2:0] lat, logic [6:0] rt, logic [127:0] data, logic we);
    s_v[p]    = 1'b1;
    s_lat[p]  = lat;
    s_rt[p]   = rt;
    s_data[p] = data;
    s_we[p]   = we;
    s_unit[p] = 3'($urandom_range(0, 7));
  endtask

  // Apply the edge that ends cycle c to the in-flight list
  task automatic model_step(int c);
    fl_t keep[$];
    bit  hit;
    if (!s_rst) begin
      inflight.delete();
      m_hz = 1'b0;
      return;
    end
    if (s_flush) begin
      inflight.delete();
      return;
    end
    foreach (inflight[i]) if (inflight[i].due > c) keep.push_back(inflight[i]);
    inflight = keep;
    for (int p = 0; p < 2; p++) begin
      if (s_v[p]) begin
        if (s_lat[p] == 3'd0 || int'(s_lat[p]) > DEPTH) begin
          m_hz = 1'b1;
        end else begin
          fl_t n;
          keep.delete();
          hit = 1'b0;
          foreach (inflight[i]) begin
            if (inflight[i].pipe == p && inflight[i].due == c + int'(s_lat[p])) hit = 1'b1;
            else keep.push_back(inflight[i]);
          end
          inflight = keep;
          if (hit) m_hz = 1'b1;
          n.due = c + int'(s_lat[p]); n.pipe = p; n.unit = s_unit[p];
          n.data = s_data[p]; n.we = s_we[p]; n.rt = s_rt[p]; n.lat = s_lat[p];
          inflight.push_back(n);
        end
      end
    end
  endtask

  task automatic push_expect(int c);
    exp_t e;
    fl_t  ep_e, op_e;
    bit   have_ep = 1'b0, have_op = 1'b0;
    int   best, bpipe;
    e.cyc = c; e.ep = '0; e.op = '0; e.hz = m_hz; e.hit = '0; e.val = '0;
    foreach (inflight[i]) begin
      if (inflight[i].due == c) begin
        if (inflight[i].pipe == 0) begin ep_e = inflight[i]; have_ep = 1'b1; end
        else begin op_e = inflight[i]; have_op = 1'b1; end
      end
    end
    if (have_ep && have_op && ep_e.we && op_e.we && ep_e.rt == op_e.rt) ep_e.we = 1'b0;
    if (have_ep) e.ep = pkt_of(ep_e);
    if (have_op) e.op = pkt_of(op_e);
`ifdef WB_FORWARD_EN
    for (int p = 0; p < FWDP; p++) begin
      best = -1; bpipe = 0;
      foreach (inflight[i]) begin
        if (inflight[i].we && inflight[i].rt == nxt_fwd[p]) begin
          if ((inflight[i].due - c) > best ||
              ((inflight[i].due - c) == best && inflight[i].pipe == 1)) begin
            best = inflight[i].due - c; bpipe = inflight[i].pipe;
            e.hit[p] = 1'b1; e.val[p] = inflight[i].data;
          end
        end
      end
    end
`endif
    sbq.push_back(e);
  endtask

  task automatic tick();
    int c;
    @(posedge clock); #1;
    c = cyc;
    reset = s_rst; flush = s_flush;
    ep_res_valid = s_v[0]; ep_res_data = s_data[0]; ep_res_rt = s_rt[0];
    ep_res_we = s_we[0]; ep_res_unit = s_unit[0]; ep_res_lat = s_lat[0];
    op_res_valid = s_v[1]; op_res_data = s_data[1]; op_res_rt = s_rt[1];
    op_res_we = s_we[1]; op_res_unit = s_unit[1]; op_res_lat = s_lat[1];
    for (int p = 0; p < FWDP; p++) fwd_addr[p] = nxt_fwd[p];
    model_step(c);
    for (int p = 0; p < FWDP; p++) nxt_fwd[p] = d_fwd_set ? d_fwd[p] : 7'($urandom_range(0, 15));
    d_fwd_set = 1'b0;
    push_expect(c + 1);
    s_v[0] = 1'b0; s_v[1] = 1'b0; s_flush = 1'b0; s_rst = 1'b1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: pops the expectation for the cycle the DUT is presenting
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        tests++; fails++;
        $display("FAIL stale_expect cyc=%0d got=none want=cycle %0d", cyc, e.cyc);
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        check("wb_ep", wrt_back_arr_ep, e.ep);
        check("wb_op", wrt_back_arr_op, e.op);
        check("wb_hazard", {142'd0, wb_hazard}, {142'd0, e.hz});
        for (int p = 0; p < FWDP; p++) begin
          check($sformatf("fwd_hit[%0d]", p), {142'd0, fwd_hit[p]}, {142'd0, e.hit[p]});
          check($sformatf("fwd_value[%0d]", p), {15'd0, fwd_value[p]}, {15'd0, e.val[p]});
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < FWDP; p++) begin
      nxt_fwd[p] = '0; d_fwd[p] = '0; fwd_addr[p] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      s_data[p] = '0; s_rt[p] = '0; s_we[p] = 1'b0; s_unit[p] = '0; s_lat[p] = '0;
    end

    s_rst = 1'b0; tick();
    s_rst = 1'b0; tick();
    s_rst = 1'b0; tick();
    idle(5);

    // Basic L=2 write on the even pipe
    stage(0, 3'd2, 7'd5, {16{8'hA5}}, 1'b1); tick();
    idle(4);

    // Same-register dual write: odd pipe keeps the write
    stage(0, 3'd4, 7'd20, {4{32'h1111_2222}}, 1'b1);
    stage(1, 3'd4, 7'd20, {4{32'h3333_4444}}, 1'b1); tick();
    idle(6);

    // Forwarding: op rt9 ends up in slot 2, ep rt9 in slot 5
    d_fwd[0] = 7'd9; d_fwd[1] = 7'd10; d_fwd[2] = 7'd9; d_fwd[3] = 7'd0; d_fwd[4] = 7'd20;
    d_fwd_set = 1'b1;
    stage(1, 3'd3, 7'd9, 128'h1, 1'b1);
    stage(0, 3'd6, 7'd9, 128'h2, 1'b1); tick();
    idle(8);

    // Slot collision raises the sticky hazard
    stage(0, 3'd4, 7'd3, {4{$urandom}}, 1'b1); tick();
    stage(0, 3'd3, 7'd4, {4{$urandom}}, 1'b1); tick();
    idle(6);
    s_rst = 1'b0; tick();
    idle(2);

    // Flush with an output still being written in the flush cycle
    stage(0, 3'd6, 7'd11, {4{$urandom}}, 1'b1);
    stage(1, 3'd1, 7'd12, {4{$urandom}}, 1'b1); tick();
    stage(1, 3'd1, 7'd13, {4{$urandom}}, 1'b1); tick();
    s_flush = 1'b1; tick();
    idle(8);

    // Illegal latency
    stage(1, 3'd0, 7'd14, {4{$urandom}}, 1'b1); tick();
    idle(2);

    // Reset mid-flight
    stage(0, 3'd5, 7'd1, {4{$urandom}}, 1'b1);
    stage(1, 3'd7, 7'd2, {4{$urandom}}, 1'b1); tick();
    idle(1);
    s_rst = 1'b0; tick();
    idle(9);

    // Randomized traffic
    for (int i = 0; i < 900; i++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          stage(p, ($urandom_range(0, 19) == 0) ? 3'd0 : 3'($urandom_range(1, DEPTH)),
                7'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom},
                ($urandom_range(0, 4) != 0));
        end
      end
      if ($urandom_range(0, 39) == 0) s_flush = 1'b1;
      if ($urandom_range(0, 99) == 0) s_rst = 1'b0;
      tick();
    end
    idle(DEPTH + 2);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clock);
    if (sbq.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain cyc=%0d got=%0d pending want=0", cyc, sbq.size());
    end
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
